// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared write-mode type, lane helper and configuration legality check for the TDP RAM.
// Ports: none (package).
`define TDP_RAM_CHECK(name, cond, msg) \
    if (!(cond)) begin : name \
        $error(msg); \
    end

package tdp_ram_pkg;
    typedef enum logic [1:0] {WRITE_FIRST, READ_FIRST, NO_CHANGE} write_mode_e;
    localparam write_mode_e WRITE_MODE = WRITE_FIRST;
    function automatic int lanes(input int dw, input int bw);
        return dw / bw;
    endfunction
endpackage

// File: rtl/tdp_ram_if.sv
// tdp_ram_if: one RAM port's request/response bundle.
// Signals: en, we[NB], addr[AW], din[DW], regce, injectsbiterr, injectdbiterr (to RAM); dout[DW] (from RAM).
interface tdp_ram_if #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int NB = 1
);
    logic          en;
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          regce;
    logic          injectsbiterr;
    logic          injectdbiterr;
    logic [DW-1:0] dout;
    modport master (output en, we, addr, din, regce, injectsbiterr, injectdbiterr, input dout);
    modport slave (input en, we, addr, din, regce, injectsbiterr, injectdbiterr, output dout);
endinterface

// File: rtl/tdp_ram_port.sv
// tdp_ram_port: lane-wise write-first access logic and read-latency output pipeline for one port.
// Ports: clk, rst, sleep; en, we, addr, din, regce (request); rd_word (current array word at addr);
//        wr, mask, word (write request to the array); dout (read data).
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int BW = 32,
    parameter int LAT = 1,
    parameter int DEPTH = 1024,
    localparam int NB = lanes(DW, BW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sleep,
    input  logic          en,
    input  logic [NB-1:0] we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          regce,
    input  logic [DW-1:0] rd_word,
    output logic          wr,
    output logic [DW-1:0] mask,
    output logic [DW-1:0] word,
    output logic [DW-1:0] dout
);
    logic          active;
    logic          in_range;
    logic [DW-1:0] pipe [LAT];

    assign active = en && !sleep;
    assign in_range = 32'(addr) < 32'(DEPTH);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) mask[i*BW +: BW] = {BW{we[i]}};
    end

    // written lanes take din (write-first), the rest keep the stored word; out-of-range reads as 0
    assign word = in_range ? (din & mask) | (rd_word & ~mask) : '0;
    assign wr = active && in_range && |we;

    // stage 1 loads on an enabled op, middle stages always shift, the last stage is gated by regce
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            if (active) pipe[0] <= word;
            for (int i = 1; i < LAT; i++)
                if (i < LAT - 1 || regce) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[LAT-1];
endmodule

// File: rtl/tdp_ram_core.sv
// tdp_ram_core: true-dual-port RAM with byte-lane write enables, write-first on both ports, port B wins on collisions.
// Ports: clk, rst (sync, clears output registers only), sleep (both ports idle);
//        port_a / port_b: tdp_ram_if.slave request/response bundles.
module tdp_ram_core
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH_A       = 10,
    parameter int ADDR_WIDTH_B       = 10,
    parameter int BYTE_WRITE_WIDTH_A = 32,
    parameter int BYTE_WRITE_WIDTH_B = 32,
    parameter int WRITE_DATA_WIDTH_A = 32,
    parameter int WRITE_DATA_WIDTH_B = 32,
    parameter int READ_DATA_WIDTH_A  = 32,
    parameter int READ_DATA_WIDTH_B  = 32,
    parameter int MEMORY_SIZE        = 32768,
    parameter int READ_LATENCY_A     = 1,
    parameter int READ_LATENCY_B     = 1
) (
    input logic clk,
    input logic rst,
    input logic sleep,
    tdp_ram_if.slave port_a,
    tdp_ram_if.slave port_b
);
    localparam int DW = WRITE_DATA_WIDTH_A;
    localparam int DEPTH = MEMORY_SIZE / DW;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    `TDP_RAM_CHECK(g_chk_rw_a, READ_DATA_WIDTH_A == WRITE_DATA_WIDTH_A, "tdp_ram_core: port A read/write widths differ")
    `TDP_RAM_CHECK(g_chk_rw_b, READ_DATA_WIDTH_B == WRITE_DATA_WIDTH_B, "tdp_ram_core: port B read/write widths differ")
    `TDP_RAM_CHECK(g_chk_ab, WRITE_DATA_WIDTH_B == WRITE_DATA_WIDTH_A, "tdp_ram_core: ports must share one data width")
    `TDP_RAM_CHECK(g_chk_bw_a, BYTE_WRITE_WIDTH_A > 0 && WRITE_DATA_WIDTH_A % BYTE_WRITE_WIDTH_A == 0, "tdp_ram_core: bad port A lane width")
    `TDP_RAM_CHECK(g_chk_bw_b, BYTE_WRITE_WIDTH_B > 0 && WRITE_DATA_WIDTH_B % BYTE_WRITE_WIDTH_B == 0, "tdp_ram_core: bad port B lane width")
    `TDP_RAM_CHECK(g_chk_size, DEPTH >= 1 && MEMORY_SIZE % DW == 0, "tdp_ram_core: MEMORY_SIZE not a whole number of words")
    `TDP_RAM_CHECK(g_chk_lat, READ_LATENCY_A >= 1 && READ_LATENCY_B >= 1, "tdp_ram_core: read latency must be at least 1")
    `TDP_RAM_CHECK(g_chk_mode, WRITE_MODE == WRITE_FIRST, "tdp_ram_core: only write-first is implemented")

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] ia, ib;
    logic [DW-1:0] rd_a, rd_b, mask_a, mask_b, word_a, word_b, base_b, store_b;
    logic          wr_a, wr_b;
    logic          unused_inject;

    assign ia = IW'(port_a.addr);
    assign ib = IW'(port_b.addr);
    assign rd_a = mem[ia];
    assign rd_b = mem[ib];

    tdp_ram_port #(
        .AW(ADDR_WIDTH_A), .DW(DW), .BW(BYTE_WRITE_WIDTH_A), .LAT(READ_LATENCY_A), .DEPTH(DEPTH)
    ) u_port_a (
        .clk(clk), .rst(rst), .sleep(sleep),
        .en(port_a.en), .we(port_a.we), .addr(port_a.addr), .din(port_a.din), .regce(port_a.regce),
        .rd_word(rd_a), .wr(wr_a), .mask(mask_a), .word(word_a), .dout(port_a.dout)
    );

    tdp_ram_port #(
        .AW(ADDR_WIDTH_B), .DW(DW), .BW(BYTE_WRITE_WIDTH_B), .LAT(READ_LATENCY_B), .DEPTH(DEPTH)
    ) u_port_b (
        .clk(clk), .rst(rst), .sleep(sleep),
        .en(port_b.en), .we(port_b.we), .addr(port_b.addr), .din(port_b.din), .regce(port_b.regce),
        .rd_word(rd_b), .wr(wr_b), .mask(mask_b), .word(word_b), .dout(port_b.dout)
    );

    // on a same-address collision B's lanes are merged over A's result so A's other lanes survive
    assign base_b = (wr_a && ia == ib) ? word_a : rd_b;
    assign store_b = (word_b & mask_b) | (base_b & ~mask_b);

    always_ff @(posedge clk) begin
        if (wr_a) mem[ia] <= word_a;
        if (wr_b) mem[ib] <= store_b;
    end

    assign unused_inject = ^{port_a.injectsbiterr, port_a.injectdbiterr, port_b.injectsbiterr, port_b.injectdbiterr};
endmodule

// File: tb/tb_tdp_ram_core.sv
// tb_tdp_ram_core: vector-table and scoreboard bench for tdp_ram_core (A latency 1, B latency 2).
module tb_tdp_ram_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sleep = 1'b0;
    always #5 clk = ~clk;

    tdp_ram_if #(.AW(10), .DW(32), .NB(4)) a_if ();
    tdp_ram_if #(.AW(10), .DW(32), .NB(4)) b_if ();

    tdp_ram_core #(
        .ADDR_WIDTH_A(10), .ADDR_WIDTH_B(10),
        .BYTE_WRITE_WIDTH_A(8), .BYTE_WRITE_WIDTH_B(8),
        .WRITE_DATA_WIDTH_A(32), .WRITE_DATA_WIDTH_B(32),
        .READ_DATA_WIDTH_A(32), .READ_DATA_WIDTH_B(32),
        .MEMORY_SIZE(32768), .READ_LATENCY_A(1), .READ_LATENCY_B(2)
    ) dut (
        .clk(clk), .rst(rst), .sleep(sleep), .port_a(a_if), .port_b(b_if)
    );

    typedef struct {
        logic        ae;
        logic [3:0]  awe;
        logic [9:0]  aa;
        logic [31:0] ad;
        logic        be;
        logic [3:0]  bwe;
        logic [9:0]  ba;
        logic [31:0] bd;
        logic        ca;
        logic [31:0] xa;
        logic        cb;
        logic [31:0] xb;
    } vec_t;

    typedef struct {
        bit          port;
        int          due;
        logic [31:0] val;
        string       name;
    } sb_t;

    vec_t vecs [16];
    sb_t  sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic sb_push(input bit port, input int lat, input logic [31:0] val, input string name);
        sb_t e;
        e.port = port;
        e.due = cyc + lat;
        e.val = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_due();
        int i;
        logic [31:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                got = sb[i].port ? b_if.dout : a_if.dout;
                checks++;
                if (got !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s: dout%s got %h expected %h (cycle %0d)",
                             sb[i].name, sb[i].port ? "b" : "a", got, sb[i].val, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_due();
    endtask

    task automatic drive(input logic ae, input logic [3:0] awe, input logic [9:0] aa, input logic [31:0] ad,
                         input logic be, input logic [3:0] bwe, input logic [9:0] ba, input logic [31:0] bd);
        a_if.en = ae;
        a_if.we = awe;
        a_if.addr = aa;
        a_if.din = ad;
        b_if.en = be;
        b_if.we = bwe;
        b_if.addr = ba;
        b_if.din = bd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 10'd5,  32'hDEADBEEF, 1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 4'h0, 10'd5,  32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'hF, 10'd7,  32'h11223344, 1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h11223344, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 10'd7,  32'hAABBCCDD, 1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 10'd7,  32'h0,        1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'hF, 10'd9,  32'h00000001, 1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h00000001, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 4'hF, 10'd9,  32'h00000002, 1'b1, 4'h0, 10'd9,  32'h0,        1'b1, 32'h00000002, 1'b1, 32'h00000001};
        vecs[7]  = '{1'b1, 4'h0, 10'd9,  32'h0,        1'b1, 4'h0, 10'd9,  32'h0,        1'b1, 32'h00000002, 1'b1, 32'h00000002};
        vecs[8]  = '{1'b1, 4'hF, 10'd3,  32'hAAAA0000, 1'b1, 4'hF, 10'd3,  32'h0000BBBB, 1'b1, 32'hAAAA0000, 1'b1, 32'h0000BBBB};
        vecs[9]  = '{1'b1, 4'h0, 10'd3,  32'h0,        1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h0000BBBB, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 10'd3,  32'h0,        1'b1, 4'h8, 10'd3,  32'h12345678, 1'b1, 32'h0000BBBB, 1'b1, 32'h1200BBBB};
        vecs[11] = '{1'b1, 4'h0, 10'd3,  32'h0,        1'b1, 4'h0, 10'd5,  32'h0,        1'b1, 32'h1200BBBB, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 4'hF, 10'd20, 32'h00000000, 1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'h00000000, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 4'h1, 10'd20, 32'h000000AA, 1'b1, 4'h8, 10'd20, 32'hBB000000, 1'b1, 32'h000000AA, 1'b1, 32'hBB000000};
        vecs[14] = '{1'b1, 4'h0, 10'd20, 32'h0,        1'b1, 4'h0, 10'd20, 32'h0,        1'b1, 32'hBB0000AA, 1'b1, 32'hBB0000AA};
        vecs[15] = '{1'b1, 4'h0, 10'd5,  32'h0,        1'b0, 4'h0, 10'd0,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};

        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        a_if.regce = 1'b1;
        b_if.regce = 1'b1;
        a_if.injectsbiterr = 1'b0;
        a_if.injectdbiterr = 1'b0;
        b_if.injectsbiterr = 1'b0;
        b_if.injectdbiterr = 1'b0;
        @(negedge clk);

        rst = 1'b1;
        sb_push(1'b0, 1, 32'h0, "reset_a");
        sb_push(1'b1, 1, 32'h0, "reset_b");
        tick();
        rst = 1'b0;

        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].ae, vecs[r].awe, vecs[r].aa, vecs[r].ad, vecs[r].be, vecs[r].bwe, vecs[r].ba, vecs[r].bd);
            if (vecs[r].ca) sb_push(1'b0, 1, vecs[r].xa, $sformatf("vec%0d_a", r));
            if (vecs[r].cb) sb_push(1'b1, 2, vecs[r].xb, $sformatf("vec%0d_b", r));
            tick();
        end

        drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0);
        sb_push(1'b0, 1, 32'hDEADBEEF, "pre_reset_a");
        tick();
        rst = 1'b1;
        drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        sb_push(1'b0, 1, 32'h0, "reset_overrides_en_a");
        sb_push(1'b1, 1, 32'h0, "reset_mid_read_b");
        tick();
        rst = 1'b0;
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        sb_push(1'b0, 1, 32'h0, "reset_hold_a");
        sb_push(1'b1, 1, 32'h0, "reset_discard_b");
        tick();
        drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        sb_push(1'b0, 1, 32'hDEADBEEF, "mem_kept_after_reset");
        tick();

        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0);
        sb_push(1'b1, 2, 32'hDEADBEEF, "lat2_read_b");
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        b_if.regce = 1'b0;
        sb_push(1'b1, 1, 32'hDEADBEEF, "regce_hold1_b");
        tick();
        sb_push(1'b1, 1, 32'hDEADBEEF, "regce_hold2_b");
        tick();
        b_if.regce = 1'b1;
        sb_push(1'b1, 1, 32'h00000002, "regce_release_b");
        tick();

        sleep = 1'b1;
        a_if.injectsbiterr = 1'b1;
        a_if.injectdbiterr = 1'b1;
        b_if.injectsbiterr = 1'b1;
        b_if.injectdbiterr = 1'b1;
        drive(1'b1, 4'hF, 10'd5, 32'h0BADF00D, 1'b1, 4'hF, 10'd9, 32'hFFFFFFFF);
        sb_push(1'b0, 1, 32'hDEADBEEF, "sleep_hold_a");
        sb_push(1'b1, 1, 32'h00000002, "sleep_hold_b");
        tick();
        sleep = 1'b0;
        drive(1'b0, 4'hF, 10'd5, 32'h0BADF00D, 1'b0, 4'hF, 10'd9, 32'hFFFFFFFF);
        sb_push(1'b0, 1, 32'hDEADBEEF, "disabled_hold_a");
        tick();
        drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
        sb_push(1'b0, 1, 32'hDEADBEEF, "no_write_while_asleep_a");
        sb_push(1'b1, 2, 32'h00000002, "no_write_while_asleep_b");
        tick();
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
